// File: rtl/regfile_param.sv
// Byte-enabled register file with reservation (busy) bits and a self-clearing INIT phase.
// Define REGFILE_BYPASS_EN to forward the same-cycle write data and busy clear to the read ports.
module regfile_param #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              WE3,
   input  logic [AW-1:0]     A3,
   input  logic [XLEN-1:0]   WD3,
   input  logic [XLEN/8-1:0] BE3,
   input  logic [AW-1:0]     A1,
   input  logic [AW-1:0]     A2,
   output logic [XLEN-1:0]   RD1,
   output logic [XLEN-1:0]   RD2,
   input  logic              RSV_EN,
   input  logic [AW-1:0]     RSV_A,
   output logic              BUSY1,
   output logic              BUSY2,
   output logic              ready
);

   typedef enum logic {INIT, RUN} state_t;

   state_t            state;
   logic [AW-1:0]     cnt;
   logic              ready_q;
   logic [XLEN-1:0]   regs [NREGS];
   logic [NREGS-1:0]  busy;
   logic              live;
   logic [AW-1:0]     rd_addr [2];
   logic [XLEN-1:0]   rd_data [2];
   logic [1:0]        busy_out;

   // The reset edge writes no register; INIT clears one entry per cycle afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= INIT;
         cnt     <= '0;
         ready_q <= 1'b0;
         busy    <= '0;
      end else begin
         case (state)
            INIT: begin
               regs[cnt] <= '0;
               cnt       <= cnt + AW'(1);
               if (cnt == AW'(NREGS - 1)) begin
                  state   <= RUN;
                  ready_q <= 1'b1;
               end
            end
            RUN: begin
               if (WE3 && A3 != '0) begin
                  for (int k = 0; k < XLEN/8; k++) begin
                     if (BE3[k]) regs[A3][8*k +: 8] <= WD3[8*k +: 8];
                  end
                  busy[A3] <= 1'b0;
               end
               // Placed after the clear so a same-address reservation wins.
               if (RSV_EN && RSV_A != '0) busy[RSV_A] <= 1'b1;
            end
            default: state <= INIT;
         endcase
      end
   end

   assign live       = ready_q && !reset;
   assign ready      = live;
   assign rd_addr[0] = A1;
   assign rd_addr[1] = A2;

   always_comb begin
      rd_data[0] = '0;
      rd_data[1] = '0;
      busy_out   = '0;
      for (int p = 0; p < 2; p++) begin
         if (live && rd_addr[p] != '0) begin
            rd_data[p]  = regs[rd_addr[p]];
            busy_out[p] = busy[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
            if (WE3 && A3 == rd_addr[p]) begin
               for (int k = 0; k < XLEN/8; k++) begin
                  if (BE3[k]) rd_data[p][8*k +: 8] = WD3[8*k +: 8];
               end
               if (!RSV_EN) busy_out[p] = 1'b0;
            end
`endif
         end
      end
   end

   assign RD1   = rd_data[0];
   assign RD2   = rd_data[1];
   assign BUSY1 = busy_out[0];
   assign BUSY2 = busy_out[1];

endmodule

// File: tb/tb_regfile_param.sv
// Randomized scoreboard bench for regfile_param against an array-based reference model.
// Honours REGFILE_BYPASS_EN the same way as the design build.
module tb_regfile_param;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = $clog2(NREGS);

   logic              clk = 1'b0;
   logic              reset;
   logic              WE3;
   logic [AW-1:0]     A3;
   logic [XLEN-1:0]   WD3;
   logic [XLEN/8-1:0] BE3;
   logic [AW-1:0]     A1, A2;
   logic [XLEN-1:0]   RD1, RD2;
   logic              RSV_EN;
   logic [AW-1:0]     RSV_A;
   logic              BUSY1, BUSY2;
   logic              ready;

   typedef struct {
      logic            rdy;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic            b1;
      logic            b2;
   } exp_t;

   exp_t exp_q [$];

   logic [XLEN-1:0] model_regs [NREGS];
   logic            model_busy [NREGS];
   int              init_left;
   int              total = 0;
   int              bad   = 0;

   regfile_param #(.XLEN(XLEN), .NREGS(NREGS)) dut (
      .clk(clk), .reset(reset), .WE3(WE3), .A3(A3), .WD3(WD3), .BE3(BE3),
      .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .RSV_EN(RSV_EN), .RSV_A(RSV_A),
      .BUSY1(BUSY1), .BUSY2(BUSY2), .ready(ready)
   );

   always #5 clk = ~clk;

   function automatic logic [XLEN-1:0] model_read(input int a);
      logic [XLEN-1:0] v;
      if (reset || init_left != 0 || a == 0) return '0;
      v = model_regs[a];
`ifdef REGFILE_BYPASS_EN
      if (WE3 && int'(A3) == a)
         for (int k = 0; k < XLEN/8; k++)
            if (BE3[k]) v[8*k +: 8] = WD3[8*k +: 8];
`endif
      return v;
   endfunction

   function automatic logic model_busy_read(input int a);
      if (reset || init_left != 0 || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (WE3 && int'(A3) == a && !RSV_EN) return 1'b0;
`endif
      return model_busy[a];
   endfunction

   task automatic checkOutput(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
      end
   endtask

   // One clock cycle: drive inputs, queue the expected outputs, then advance the model across the edge.
   task automatic applyStimulus(input logic rst, input logic we, input int a3, input logic [XLEN-1:0] wd,
                                input logic [XLEN/8-1:0] be, input logic rsv, input int rsva,
                                input int a1, input int a2);
      exp_t e;
      reset = rst; WE3 = we; A3 = AW'(a3); WD3 = wd; BE3 = be;
      RSV_EN = rsv; RSV_A = AW'(rsva); A1 = AW'(a1); A2 = AW'(a2);
      e.rdy = !rst && init_left == 0;
      e.rd1 = model_read(a1);
      e.rd2 = model_read(a2);
      e.b1  = model_busy_read(a1);
      e.b2  = model_busy_read(a2);
      exp_q.push_back(e);
      @(posedge clk);
      if (rst) begin
         for (int r = 0; r < NREGS; r++) begin
            model_regs[r] = '0;
            model_busy[r] = 1'b0;
         end
         init_left = NREGS;
      end else if (init_left > 0) begin
         init_left--;
      end else begin
         if (we && a3 != 0) begin
            for (int k = 0; k < XLEN/8; k++)
               if (be[k]) model_regs[a3][8*k +: 8] = wd[8*k +: 8];
            model_busy[a3] = 1'b0;
         end
         if (rsv && rsva != 0) model_busy[rsva] = 1'b1;
      end
      #1;
   endtask

   task automatic idle(input int a1, input int a2);
      applyStimulus(1'b0, 1'b0, 0, '0, '0, 1'b0, 0, a1, a2);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("ready", XLEN'(ready), XLEN'(e.rdy));
            checkOutput("RD1",   RD1,          e.rd1);
            checkOutput("RD2",   RD2,          e.rd2);
            checkOutput("BUSY1", XLEN'(BUSY1), XLEN'(e.b1));
            checkOutput("BUSY2", XLEN'(BUSY2), XLEN'(e.b2));
         end
      end
   end

   initial begin
      int drain;
      init_left = NREGS;
      for (int r = 0; r < NREGS; r++) begin
         model_regs[r] = '0;
         model_busy[r] = 1'b0;
      end
      reset = 1'b1; WE3 = 1'b0; A3 = '0; WD3 = '0; BE3 = '0;
      RSV_EN = 1'b0; RSV_A = '0; A1 = '0; A2 = '0;
      @(posedge clk);
      #1;

      applyStimulus(1'b1, 1'b0, 0, '0, '0, 1'b0, 0, 1, 2);
      // Writes and reservations during INIT must be ignored.
      for (int c = 0; c < NREGS; c++)
         applyStimulus(1'b0, 1'b1, 4, 32'hFFFF_FFFF, 4'hF, 1'b1, 4, c, 4);
      for (int r = 0; r < 4; r++) idle(r, NREGS - 1 - r);

      applyStimulus(1'b0, 1'b1, 5, 32'hDEAD_BEEF, 4'hF, 1'b0, 0, 5, 6);
      applyStimulus(1'b0, 1'b1, 5, 32'h0000_00AA, 4'h1, 1'b0, 0, 5, 5);
      idle(5, 0);

      applyStimulus(1'b0, 1'b0, 0, '0, '0, 1'b1, 7, 7, 5);
      idle(7, 5);
      applyStimulus(1'b0, 1'b1, 7, 32'h0000_1111, 4'hF, 1'b0, 0, 7, 7);
      idle(7, 2);
      applyStimulus(1'b0, 1'b1, 7, 32'h0000_2222, 4'hF, 1'b1, 7, 7, 7);
      idle(7, 7);
      applyStimulus(1'b0, 1'b0, 0, '0, '0, 1'b1, 7, 7, 7);
      idle(7, 7);

      applyStimulus(1'b0, 1'b1, 0, 32'hFFFF_FFFF, 4'hF, 1'b1, 0, 0, 0);
      idle(0, 0);

      applyStimulus(1'b0, 1'b0, 0, '0, '0, 1'b1, 9, 9, 9);
      applyStimulus(1'b0, 1'b1, 9, 32'h5555_5555, 4'h0, 1'b0, 0, 9, 9);
      idle(9, 9);

      applyStimulus(1'b0, 1'b1, 3, 32'h1234_5678, 4'hF, 1'b0, 0, 3, 3);
      idle(3, 3);

      // Reset partway through INIT restarts the clear sequence.
      applyStimulus(1'b1, 1'b0, 0, '0, '0, 1'b0, 0, 3, 5);
      for (int c = 0; c < 10; c++) idle(3, 5);
      applyStimulus(1'b1, 1'b0, 0, '0, '0, 1'b0, 0, 3, 5);
      for (int c = 0; c < NREGS + 3; c++) idle(3, 5);

      for (int n = 0; n < 600; n++) begin
         applyStimulus(($urandom_range(0, 249) == 0), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 7)), XLEN'($urandom),
                       (XLEN/8)'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, NREGS - 1)));
      end

      drain = 0;
      while (exp_q.size() > 0 && drain < 10) begin
         @(negedge clk);
         drain++;
      end
      #2;
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("[TB] FAIL drain: got %0d pending expected 0 pending", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
